// File: rtl/ofs_plat_prim_lutram_pkg.sv
// Shared types and elaboration helpers for the
// multi-write / multi-read LUTRAM.
package ofs_plat_prim_lutram_pkg;

  typedef enum logic [1:0] {
    OLD_DATA,
    NEW_DATA,
    DONT_CARE
  } t_rdw_mode;

  // Unknown strings fall back to the safest mode.
  function automatic t_rdw_mode rdw_mode(input string s);
    if (s == "NEW_DATA") return NEW_DATA;
    if (s == "DONT_CARE") return DONT_CARE;
    return OLD_DATA;
  endfunction

  // 1-bit words are padded so the array maps to MLAB.
  function automatic int pad_bits(input int n);
    return (n == 1) ? 2 : n;
  endfunction

  function automatic int lvt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_lutram_lvt.sv
// Live-value table: remembers which writer last
// updated each entry. Constant 0 for one writer.
module ofs_plat_prim_lutram_lvt
  import ofs_plat_prim_lutram_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_WRITERS = 2,
  parameter int N_READERS = 2,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int LW = lvt_bits(N_WRITERS)
) (
  input  logic                          clk,
  input  logic [N_WRITERS-1:0]          wen,
  input  logic [N_WRITERS-1:0][AW-1:0]  waddr,
  input  logic [N_READERS-1:0][AW-1:0]  raddr,
  output logic [N_READERS-1:0][LW-1:0]  rsel
);

  if (N_WRITERS > 1) begin : g_tbl
    logic [LW-1:0] tbl [N_ENTRIES];

    // Later writers overwrite earlier ones on a shared address.
    always_ff @(posedge clk) begin
      for (int w = 0; w < N_WRITERS; w++) begin
        if (wen[w]) tbl[waddr[w]] <= LW'(w);
      end
    end

    for (genvar r = 0; r < N_READERS; r++) begin : g_rd
      assign rsel[r] = tbl[raddr[r]];
    end
  end else begin : g_const
    logic unused_ports;
    assign unused_ports = ^{clk, wen, waddr, raddr};
    assign rsel = '0;
  end

endmodule

// File: rtl/ofs_plat_prim_lutram_mwmr.sv
// Multi-write, multi-read LUTRAM built from one bank
// per (writer, reader) pair plus a live-value table.
module ofs_plat_prim_lutram_mwmr
  import ofs_plat_prim_lutram_pkg::*;
#(
  parameter int N_ENTRIES = 32,
  parameter int N_DATA_BITS = 64,
  parameter int N_WRITERS = 2,
  parameter int N_READERS = 2,
  parameter logic [N_DATA_BITS-1:0] INIT_VALUE = '0,
  parameter string READ_DURING_WRITE = "OLD_DATA",
  localparam int AW = $clog2(N_ENTRIES),
  localparam int DW = pad_bits(N_DATA_BITS),
  localparam int LW = lvt_bits(N_WRITERS)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  output logic                                  rdy,
  input  logic [N_READERS-1:0][AW-1:0]          raddr,
  output logic [N_READERS-1:0][N_DATA_BITS-1:0] rdata,
  input  logic [N_WRITERS-1:0][AW-1:0]          waddr,
  input  logic [N_WRITERS-1:0]                  wen,
  input  logic [N_WRITERS-1:0][N_DATA_BITS-1:0] wdata
);

  localparam t_rdw_mode MODE = rdw_mode(READ_DURING_WRITE);

  logic [AW-1:0]                 init_addr;
  logic [N_WRITERS-1:0]          u_wen;
  logic [N_WRITERS-1:0][DW-1:0]  wdata_p;
  logic [N_WRITERS-1:0]          s_wen;
  logic [N_WRITERS-1:0][AW-1:0]  s_waddr;
  logic [N_WRITERS-1:0][DW-1:0]  s_wdata;
  logic [N_WRITERS-1:0]          c_wen;
  logic [N_WRITERS-1:0][AW-1:0]  c_waddr;
  logic [N_WRITERS-1:0][DW-1:0]  c_wdata;
  logic [N_READERS-1:0][LW-1:0]  rsel;
  logic [DW-1:0]                 bank_rd [N_WRITERS][N_READERS];
  logic [N_READERS-1:0][DW-1:0]  rd_full;

  // Walk every address once after reset, then hold rdy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_addr <= '0;
      rdy       <= 1'b0;
    end else if (!rdy) begin
      init_addr <= init_addr + 1'b1;
      if (init_addr == AW'(N_ENTRIES - 1)) rdy <= 1'b1;
    end
  end

  assign u_wen = wen & {N_WRITERS{rdy}};

  for (genvar w = 0; w < N_WRITERS; w++) begin : g_pad
    assign wdata_p[w] = DW'(wdata[w]);
  end

  if (MODE == OLD_DATA) begin : g_dly
    // Accepted writes commit one cycle late; reads bypass meanwhile.
    always_ff @(posedge clk) begin
      if (!reset_n) s_wen <= '0;
      else          s_wen <= u_wen;
      s_waddr <= waddr;
      s_wdata <= wdata_p;
    end
  end else begin : g_nodly
    assign s_wen   = u_wen;
    assign s_waddr = waddr;
    assign s_wdata = wdata_p;
  end

  // Writer 0's port is borrowed for init until rdy.
  always_comb begin
    c_wen   = s_wen;
    c_waddr = s_waddr;
    c_wdata = s_wdata;
    if (!rdy) begin
      c_wen      = '0;
      c_wen[0]   = reset_n;
      c_waddr[0] = init_addr;
      c_wdata[0] = DW'(INIT_VALUE);
    end
  end

  ofs_plat_prim_lutram_lvt #(
    .N_ENTRIES (N_ENTRIES),
    .N_WRITERS (N_WRITERS),
    .N_READERS (N_READERS)
  ) lvt (
    .clk   (clk),
    .wen   (c_wen),
    .waddr (c_waddr),
    .raddr (raddr),
    .rsel  (rsel)
  );

  for (genvar w = 0; w < N_WRITERS; w++) begin : g_w
    for (genvar r = 0; r < N_READERS; r++) begin : g_r
      (* ramstyle = "MLAB, no_rw_check" *)
      logic [DW-1:0] mem [N_ENTRIES];

      // Single write port, asynchronous read port.
      always_ff @(posedge clk) begin
        if (c_wen[w]) mem[c_waddr[w]] <= c_wdata[w];
      end

      assign bank_rd[w][r] = mem[raddr[r]];
    end
  end

  // Pick the live bank, then apply the mode's bypass.
  always_comb begin
    rd_full = '0;
    for (int r = 0; r < N_READERS; r++) begin
      rd_full[r] = bank_rd[0][r];
      for (int w = 0; w < N_WRITERS; w++) begin
        if (rsel[r] == LW'(w)) rd_full[r] = bank_rd[w][r];
      end
      if (MODE != DONT_CARE) begin
        for (int w = 0; w < N_WRITERS; w++) begin
          if (s_wen[w] && (s_waddr[w] == raddr[r]))
            rd_full[r] = s_wdata[w];
        end
      end
    end
  end

  for (genvar r = 0; r < N_READERS; r++) begin : g_out
    assign rdata[r] = rd_full[r][N_DATA_BITS-1:0];
    if (DW > N_DATA_BITS) begin : g_drop
      logic unused_pad;
      assign unused_pad = ^rd_full[r][DW-1:N_DATA_BITS];
    end
  end

endmodule
